// File: rtl/vdc_pi_servo_if.sv
// Signal bundle between the error source / PWM block and the PI servo stage.
// err_valid is a one-cycle strobe with no ready: a strobe arriving while busy=1 is dropped and latches ovr.
interface vdc_pi_servo_if;
  logic               on;
  logic               hold;
  logic signed [15:0] err;
  logic               err_valid;
  logic signed [15:0] kp;
  logic signed [15:0] ki;
  logic signed [31:0] nh_ff;
  logic signed [31:0] NT;
  logic signed [31:0] NH;
  logic               nh_valid;
  logic               sat_hi;
  logic               sat_lo;
  logic               busy;
  logic               ovr;
  logic               vdc_trig;
  logic [2:0]         state_dbg;
  logic signed [47:0] integ_dbg;

  modport master (
    output on, hold, err, err_valid, kp, ki, nh_ff, NT,
    input  NH, nh_valid, sat_hi, sat_lo, busy, ovr, vdc_trig, state_dbg, integ_dbg
  );

  modport slave (
    input  on, hold, err, err_valid, kp, ki, nh_ff, NT,
    output NH, nh_valid, sat_hi, sat_lo, busy, ovr, vdc_trig, state_dbg, integ_dbg
  );
endinterface

// File: rtl/vdc_pi_servo.sv
// PI servo producing the PWM high-count NH in [0, NT] with conditional-integration
// anti-windup, plus the shared period trigger vdc_trig.
module vdc_pi_servo #(
  parameter int unsigned        PS   = 8,
  parameter int unsigned        IS   = 16,
  parameter logic signed [47:0] IMAX = 48'sh3FFF_FFFF_FFFF
) (
  input logic           clk,
  input logic           rst,
  vdc_pi_servo_if.slave bus
);

  typedef enum logic [2:0] {IDLE = 3'd0, MUL = 3'd1, ACC = 3'd2, SUM = 3'd3, CLAMP = 3'd4} state_t;

  localparam logic signed [48:0] IMAX49 = {IMAX[47], IMAX};

  state_t             state_q, state_d;
  logic signed [15:0] err_q, kp_q, ki_q;
  logic signed [31:0] ff_q, p_q, di_q, nh_q;
  logic signed [47:0] integ_q;
  logic signed [49:0] u_q;
  logic               nh_valid_q, sat_hi_q, sat_lo_q, ovr_q, trig_q;
  logic [31:0]        tcnt_q;

  logic signed [48:0] acc_sum;
  logic signed [47:0] acc_sat;
  logic               acc_skip;
  logic signed [31:0] p_sh;
  logic signed [47:0] i_sh;
  logic signed [49:0] sum_u;
  logic signed [49:0] nt50;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.on) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.err_valid) state_d = MUL;
        MUL:     state_d = ACC;
        ACC:     state_d = SUM;
        SUM:     state_d = CLAMP;
        CLAMP:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Integrator step is frozen by hold, or when it would push further into the clamp just hit.
  always_comb begin
    acc_sum  = {integ_q[47], integ_q} + {{17{di_q[31]}}, di_q};
    acc_sat  = acc_sum[47:0];
    if (acc_sum > IMAX49)       acc_sat = IMAX;
    else if (acc_sum < -IMAX49) acc_sat = -IMAX;
    acc_skip = bus.hold || (sat_hi_q && (di_q > 32'sd0)) || (sat_lo_q && (di_q < 32'sd0));
    p_sh     = p_q >>> PS;
    i_sh     = integ_q >>> IS;
    sum_u    = {{18{p_sh[31]}}, p_sh} + {{2{i_sh[47]}}, i_sh} + {{18{ff_q[31]}}, ff_q};
    nt50     = {{18{bus.NT[31]}}, bus.NT};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q      <= '0;
      kp_q       <= '0;
      ki_q       <= '0;
      ff_q       <= '0;
      p_q        <= '0;
      di_q       <= '0;
      integ_q    <= '0;
      u_q        <= '0;
      nh_q       <= '0;
      nh_valid_q <= 1'b0;
      sat_hi_q   <= 1'b0;
      sat_lo_q   <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      nh_valid_q <= 1'b0;
      if (!bus.on) begin
        integ_q  <= '0;
        nh_q     <= '0;
        sat_hi_q <= 1'b0;
        sat_lo_q <= 1'b0;
        ovr_q    <= 1'b0;
      end else begin
        if (bus.err_valid && (state_q != IDLE)) ovr_q <= 1'b1;
        case (state_q)
          IDLE: begin
            if (bus.err_valid) begin
              err_q <= bus.err;
              kp_q  <= bus.kp;
              ki_q  <= bus.ki;
              ff_q  <= bus.nh_ff;
            end
          end
          MUL: begin
            p_q  <= 32'(kp_q) * 32'(err_q);
            di_q <= 32'(ki_q) * 32'(err_q);
          end
          ACC: if (!acc_skip) integ_q <= acc_sat;
          SUM: u_q <= sum_u;
          CLAMP: begin
            nh_valid_q <= 1'b1;
            if (bus.NT <= 32'sd0) begin
              nh_q     <= '0;
              sat_hi_q <= 1'b0;
              sat_lo_q <= 1'b0;
            end else if (u_q < 50'sd0) begin
              nh_q     <= '0;
              sat_hi_q <= 1'b0;
              sat_lo_q <= 1'b1;
            end else if (u_q > nt50) begin
              nh_q     <= bus.NT;
              sat_hi_q <= 1'b1;
              sat_lo_q <= 1'b0;
            end else begin
              nh_q     <= u_q[31:0];
              sat_hi_q <= 1'b0;
              sat_lo_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Period counter runs regardless of on; the >= compare lets an NT shrink wrap on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q <= '0;
      trig_q <= 1'b0;
    end else if (bus.NT <= 32'sd1) begin
      tcnt_q <= '0;
      trig_q <= 1'b0;
    end else if ($signed(tcnt_q) >= (bus.NT - 32'sd1)) begin
      tcnt_q <= '0;
      trig_q <= 1'b1;
    end else begin
      tcnt_q <= tcnt_q + 32'd1;
      trig_q <= 1'b0;
    end
  end

  assign bus.NH        = nh_q;
  assign bus.nh_valid  = nh_valid_q;
  assign bus.sat_hi    = sat_hi_q;
  assign bus.sat_lo    = sat_lo_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.ovr       = ovr_q;
  assign bus.vdc_trig  = trig_q;
  assign bus.state_dbg = state_q;
  assign bus.integ_dbg = integ_q;

endmodule

// File: tb/tb_vdc_pi_servo.sv
// Directed bench for vdc_pi_servo: a sample-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_vdc_pi_servo;
  localparam int unsigned PS = 0;
  localparam int unsigned IS = 16;
  localparam longint IMAX_L = (longint'(1) <<< 46) - 1;

  logic clk = 1'b0;
  logic rst;
  vdc_pi_servo_if bus ();

  vdc_pi_servo #(.PS(PS), .IS(IS)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one accepted sample yields a result 4 edges later
  longint m_integ = 0, m_nh = 0, m_tcnt = 0;
  longint l_err = 0, l_kp = 0, l_ki = 0, l_ff = 0;
  int     m_left = 0;
  logic   m_hi = 0, m_lo = 0, m_ovr = 0, m_valid = 0, m_trig = 0;

  always @(posedge clk or posedge rst) begin
    longint s, u, nt, di;
    if (rst) begin
      m_integ = 0; m_nh = 0; m_tcnt = 0; m_left = 0;
      m_hi = 0; m_lo = 0; m_ovr = 0; m_valid = 0; m_trig = 0;
    end else begin
      nt = longint'(bus.NT);
      if (nt <= 1) begin m_tcnt = 0; m_trig = 0; end
      else if (m_tcnt >= nt - 1) begin m_tcnt = 0; m_trig = 1; end
      else begin m_tcnt = m_tcnt + 1; m_trig = 0; end

      m_valid = 0;
      if (!bus.on) begin
        m_left = 0; m_integ = 0; m_nh = 0; m_hi = 0; m_lo = 0; m_ovr = 0;
      end else if (m_left > 0) begin
        if (bus.err_valid) m_ovr = 1;
        m_left = m_left - 1;
        di = l_ki * l_err;
        if (m_left == 2 && !bus.hold && !(m_hi && di > 0) && !(m_lo && di < 0)) begin
          s = m_integ + di;
          if (s > IMAX_L) s = IMAX_L;
          if (s < -IMAX_L) s = -IMAX_L;
          m_integ = s;
        end
        if (m_left == 0) begin
          u = ((l_kp * l_err) >>> PS) + (m_integ >>> IS) + l_ff;
          m_valid = 1;
          if (nt <= 0)      begin m_nh = 0;  m_hi = 0; m_lo = 0; end
          else if (u < 0)   begin m_nh = 0;  m_hi = 0; m_lo = 1; end
          else if (u > nt)  begin m_nh = nt; m_hi = 1; m_lo = 0; end
          else              begin m_nh = u;  m_hi = 0; m_lo = 0; end
        end
      end else if (bus.err_valid) begin
        l_err = longint'(bus.err); l_kp = longint'(bus.kp);
        l_ki = longint'(bus.ki);   l_ff = longint'(bus.nh_ff);
        m_left = 4;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    chk("m_nh",       bus.NH,        m_nh);
    chk("m_nh_valid", bus.nh_valid,  m_valid);
    chk("m_sat_hi",   bus.sat_hi,    m_hi);
    chk("m_sat_lo",   bus.sat_lo,    m_lo);
    chk("m_busy",     bus.busy,      m_left > 0);
    chk("m_ovr",      bus.ovr,       m_ovr);
    chk("m_trig",     bus.vdc_trig,  m_trig);
    chk("m_integ",    bus.integ_dbg, m_integ);
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic signed [15:0] e);
    bus.err = e;
    bus.err_valid = 1'b1;
    tick();
    bus.err_valid = 1'b0;
  endtask

  task automatic wait_nh();
    int n = 0;
    while (!bus.nh_valid && n < 12) begin
      tick();
      n++;
    end
    chk("nh_timeout", bus.nh_valid, 1);
  endtask

  task automatic sample(input logic signed [15:0] e);
    pulse(e);
    wait_nh();
  endtask

  task automatic set_gains(input int kp, input int ki, input int ff);
    bus.kp = 16'(kp);
    bus.ki = 16'(ki);
    bus.nh_ff = ff;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.on = 1'b0; bus.hold = 1'b0; bus.err = '0; bus.err_valid = 1'b0;
    set_gains(0, 0, 0);
    bus.NT = 100000;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_nh", bus.NH, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ovr", bus.ovr, 0);
    bus.on = 1'b1;

    // basic P + feed-forward: 2*100 + 1000
    set_gains(2, 0, 1000);
    pulse(100);
    chk("t1_busy_k", bus.busy, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_busy_mid", bus.busy, 1);
      chk("t1_valid_mid", bus.nh_valid, 0);
    end
    tick();
    chk("t1_valid", bus.nh_valid, 1);
    chk("t1_nh", bus.NH, 1200);
    chk("t1_busy_end", bus.busy, 0);
    tick();
    chk("t1_valid_once", bus.nh_valid, 0);
    chk("t1_nh_stable", bus.NH, 1200);

    // clamp high then low
    set_gains(1000, 0, 0);
    sample(200);
    chk("t2_nh_hi", bus.NH, 100000);
    chk("t2_sat_hi", bus.sat_hi, 1);
    sample(-200);
    chk("t2_nh_lo", bus.NH, 0);
    chk("t2_sat_lo", bus.sat_lo, 1);
    chk("t2_sat_hi0", bus.sat_hi, 0);

    // anti-windup: sat_lo lets +1 in, then sat_hi blocks further +1 steps
    set_gains(0, 1, 200000);
    sample(1);
    chk("t3_integ1", bus.integ_dbg, 1);
    chk("t3_sat_hi", bus.sat_hi, 1);
    repeat (3) sample(1);
    chk("t3_integ_held", bus.integ_dbg, 1);
    sample(-1);
    chk("t3_integ_dec", bus.integ_dbg, 0);
    bus.hold = 1'b1;
    sample(-1);
    chk("t3_hold", bus.integ_dbg, 0);
    bus.hold = 1'b0;
    sample(-1);
    chk("t3_integ_neg", bus.integ_dbg, -1);

    // overrun: strobes at edges 0 and 2, result at 4 = 10 + (-1>>>16) + 500
    set_gains(1, 0, 500);
    bus.err = 10; bus.err_valid = 1'b1; tick();
    bus.err_valid = 1'b0; tick();
    bus.err_valid = 1'b1; tick();
    bus.err_valid = 1'b0; tick();
    tick();
    chk("t4_valid", bus.nh_valid, 1);
    chk("t4_nh", bus.NH, 509);
    chk("t4_ovr", bus.ovr, 1);
    pulse(20);
    wait_nh();
    chk("t4_nh2", bus.NH, 519);
    bus.on = 1'b0;
    tick();
    chk("t4_off_ovr", bus.ovr, 0);
    chk("t4_off_nh", bus.NH, 0);
    chk("t4_off_integ", bus.integ_dbg, 0);
    bus.on = 1'b1;

    // trigger: NT=10 from reset, shrink to 4 at tcnt=7, then NT=1
    rst = 1'b1;
    bus.NT = 10;
    repeat (2) tick();
    rst = 1'b0;
    for (int n = 1; n <= 37; n++) begin
      tick();
      if (n <= 30) chk("t5_trig10", bus.vdc_trig, (n % 10) == 0);
    end
    bus.NT = 4;
    for (int n = 38; n <= 46; n++) begin
      tick();
      chk("t5_trig4", bus.vdc_trig, (n == 38) || (n == 42) || (n == 46));
    end
    bus.NT = 1;
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("t5_trig1", bus.vdc_trig, 0);
    end
    bus.NT = 100000;

    // async reset mid-pipeline
    set_gains(2, 0, 1000);
    sample(100);
    chk("t6_pre", bus.NH, 1200);
    tick();
    pulse(50);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_nh", bus.NH, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_valid", bus.nh_valid, 0);
    chk("t6_rst_integ", bus.integ_dbg, 0);
    tick();
    tick();
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("t6_no_valid", bus.nh_valid, 0);
    end
    sample(100);
    chk("t6_post_nh", bus.NH, 1200);
    chk("t6_post_integ", bus.integ_dbg, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vdc_pi_servo.md
# vdc_pi_servo

PI servo stage that directly feeds the variable-duty-cycle PWM block. It converts a signed error sample into a high-count NH, clamped to [0, NT], with conditional-integration anti-windup. It also generates the shared one-cycle vdc_trig that synchronizes every PWM channel. One instance drives one PWM channel; the vdc_trig of a single designated instance is fanned out to all channels.

## Interface
- PS, 8: right arithmetic shift applied to the proportional product
- IS, 16: right arithmetic shift applied to the integrator before summing
- IMAX, 48'sh3FFF_FFFF_FFFF: symmetric integrator saturation magnitude (integrator held in [-IMAX, +IMAX])
- clk  in  1  system clock (100 MHz); one clock domain
- rst  in  1  asynchronous, active-high reset
- on  in  1  servo enable; low clears the loop
- hold  in  1  freezes the integrator; P path still active
- err  in  16 signed  error sample
- err_valid  in  1  error strobe, one cycle
- kp, ki  in  16 signed each  proportional / integral gains
- nh_ff  in  32 signed  feed-forward added to the sum
- NT  in  32 signed  PWM period in clk cycles
- NH  out  32 signed  high-count to the PWM block
- nh_valid  out  1  one-cycle pulse when NH updates
- sat_hi, sat_lo  out  1 each  last result clamped at NT / at 0
- busy  out  1  pipeline occupied
- ovr  out  1  sticky: err_valid arrived while busy
- vdc_trig  out  1  one-cycle period marker, every NT cycles

## Operation
- Reset values: NH=0, nh_valid=0, sat_hi=sat_lo=0, busy=0, ovr=0, vdc_trig=0, integrator=0, trig counter=0, state=IDLE.
- FSM states, one edge each: IDLE -> MUL -> ACC -> SUM -> CLAMP -> IDLE.
- IDLE: if on && err_valid, latch err, kp, ki, nh_ff and go to MUL. Otherwise stay.
- MUL: p = kp*err and di = ki*err, both 32-bit signed, registered.
- ACC: integ = sat(integ + di, ±IMAX), in 48-bit signed.
  - The update is skipped if hold=1.
  - It is also skipped if sat_hi=1 and di>0, or if sat_lo=1 and di<0 (flags from the previous result).
- SUM: u = (p>>>PS) + (integ>>>IS) + nh_ff, computed in 50-bit signed. No wrap is permitted.
- CLAMP:
  - NT<=0: NH=0, sat_hi=sat_lo=0.
  - u<0: NH=0, sat_lo=1, sat_hi=0.
  - u>NT: NH=NT, sat_hi=1, sat_lo=0.
  - Otherwise: NH=u[31:0], both flags 0.
  - nh_valid=1 for this edge only.
- busy=1 in every state except IDLE.
- err_valid while busy is dropped and sets ovr. ovr clears only on rst or on=0.
- on=0, synchronous and taking priority over everything except rst:
  - state forced to IDLE, integrator=0, NH=0, sat flags=0, ovr=0, nh_valid=0.
  - The trig counter is unaffected.
- Trig generator, independent of on:
  - 32-bit counter tcnt. If tcnt>=NT-1, then tcnt<=0 and vdc_trig<=1; else tcnt<=tcnt+1 and vdc_trig<=0.
  - NT<=1: tcnt held at 0, vdc_trig=0.
  - A change in NT takes effect immediately through the >= compare, so a shrink mid-period wraps on the next edge.
- rst asserted mid-pipeline: all registers go to their reset values asynchronously. The in-flight sample is lost and no nh_valid is produced.

## Timing
- err_valid sampled high at edge k (IDLE, on=1) -> NH and nh_valid updated at edge k+4. busy is high after edges k..k+3 and low after edge k+4.
- Minimum accepted sample spacing is 5 cycles. err_valid at edge k+4 is dropped (ovr set); err_valid at edge k+5 is accepted.
- NH is stable between nh_valid pulses. The PWM block samples it at its own cnt==0, so no further alignment is required.
- vdc_trig: first pulse is registered at edge NT after rst release (tcnt reaches NT-1 at edge NT-1). Pulses then repeat every NT cycles.
- Anti-windup flags used in ACC are those registered at the preceding CLAMP.

## Test plan
- PS=0, IS=16, kp=2, ki=0, nh_ff=1000, NT=100000. err=100 at edge 10 -> NH=1200 at edge 14, nh_valid high only at edge 14, busy high after edges 10–13.
- Clamp: kp=1000, err=200, nh_ff=0, NT=100000 -> NH=100000, sat_hi=1. Then err=-200 -> NH=0, sat_lo=1.
- Anti-windup: ki=1, err=+1 fed repeatedly while sat_hi=1 -> integrator unchanged. Then err=-1 -> integrator decrements by 1.
- Overrun: err_valid at edges 0 and 2 -> one nh_valid at edge 4, ovr=1. err_valid at edge 5 is accepted. Drop on to 0 -> ovr=0, NH=0, integrator=0.
- Trig: NT=10 -> vdc_trig at edges 10, 20, 30. NT changed to 4 while tcnt=7 -> pulse on the next edge, then every 4 cycles. NT=1 -> no pulses.
- Reset: assert rst asynchronously between edges k+2 and k+3 of a sample -> all outputs 0 immediately, no nh_valid. After release the integrator is 0 and the next sample behaves as the first test.
